fp_sqrt_ctrl: RTL
=================

Name: fp_sqrt_ctrl

Overview:
Control unit for the floating-point square-root datapath. It accepts a start request with an IEEE-754 single-precision operand and classifies special operands. It drives the output-enable strobes of the datapath registers (operand, remainder/root iteration, result) through a digit-recurrence sequence of ITER cycles. It reports completion with a one-cycle done pulse and an invalid-operation flag.

Parameters:
DATA_WIDTH, 32, operand width (IEEE-754 single; fixed layout sign[31], exp[30:23], frac[22:0])
ITER, 24, number of root-digit iterations (one root bit per cycle)
CNT_WIDTH, 5, width of iteration counter; must satisfy 2^CNT_WIDTH > ITER

Ports:
clk  input  1  system clock, all logic on rising edge
rst_ni  input  1  synchronous active-low reset
start_i  input  1  request to begin a square root; sampled only in IDLE
data_i  input  DATA_WIDTH  operand; sampled on the start edge
busy_o  output  1  high in every state except IDLE
op_oe_o  output  1  OE to datapath operand register (load operand)
iter_oe_o  output  1  OE to remainder/root iteration registers
res_oe_o  output  1  OE to result register
res_sel_o  output  2  result mux select: 00 computed, 01 +0/-0 (sign from operand), 10 +inf, 11 quiet NaN 0x7FC00000
iter_cnt_o  output  CNT_WIDTH  current iteration index
done_o  output  1  one-cycle completion pulse
invalid_o  output  1  NaN result due to invalid operand; valid with done_o

Behaviour:
- Reset (rst_ni=0 at a rising edge): state=IDLE; all outputs 0, iter_cnt_o=0, res_sel_o=00. Reset applies mid-operation: any state returns to IDLE next edge, with no done_o.
- Outputs are Moore, decoded from registered state/flags. No combinational path from inputs to outputs.
- States: IDLE, LOAD, CLASSIFY, ITER, NORM, DONE.
- IDLE: if start_i=1, capture sign, exp, and (frac!=0) from data_i into internal flags; next state is LOAD. Otherwise stay.
- LOAD (1 cycle): op_oe_o=1. Next state is CLASSIFY.
- CLASSIFY (1 cycle): evaluate the special cases in order:
  - exp=FF and frac!=0 (NaN in): res_sel=11, invalid=0.
  - sign=1 and not zero (exp!=0 or frac!=0): res_sel=11, invalid=1.
  - exp=FF and frac=0 (+inf): res_sel=10.
  - exp=0 and frac=0 (±0): res_sel=01.
  - Special case: next state is DONE. Otherwise res_sel=00, iter_cnt=0, next state is ITER.
  - Denormals (exp=0, frac!=0, sign=0) are flushed: res_sel=01, result +0.
- ITER: iter_oe_o=1; iter_cnt_o increments each cycle. On the cycle iter_cnt_o=ITER-1, next state is NORM and the counter holds at ITER-1. ITER lasts exactly ITER cycles.
- NORM (1 cycle): res_oe_o=1. Next state is DONE.
- Special path: res_oe_o=1 in the DONE cycle itself, so the result register loads the constant.
- DONE (1 cycle): done_o=1, invalid_o per classification. Next state is IDLE. iter_cnt_o resets to 0 on leaving DONE.
- Latency, with the start edge as cycle 0:
  - Normal operand: done_o high in cycle ITER+4 (28 for default).
  - Special operand: done_o high in cycle 3.
- start_i while busy_o=1 is ignored, with no queuing. start_i asserted in the DONE cycle is also ignored. A new start is accepted one cycle after done_o.
- res_sel_o and invalid_o hold their value from CLASSIFY until the next LOAD; they do not clear in IDLE.

Test Plan:
1. rst_ni=0 for 2 cycles while a start is in flight (state ITER) -> all outputs 0, state IDLE, no done_o; start after release works.
2. start_i=1, data_i=0x40800000 (4.0) -> op_oe_o in cycle 1; iter_oe_o high in cycles 3..26 with iter_cnt_o 0..23; res_oe_o in cycle 27; done_o in cycle 28; res_sel_o=00, invalid_o=0.
3. data_i=0xC0000000 (-2.0) -> done_o in cycle 3; res_sel_o=11, invalid_o=1, res_oe_o=1 in cycle 3; iter_oe_o never asserted.
4. data_i=0x80000000 (-0), then 0x7F800000 (+inf), then 0x7FC00001 (NaN) -> res_sel 01/10/11 respectively, invalid_o=0 for all three, each done in cycle 3.
5. start_i held high continuously with operand 0x41100000 (9.0) -> exactly one operation per 29-cycle period (done, IDLE, restart). Start pulses in cycles 5 and 28 are ignored.
6. ITER=4 parameter override, operand 0x3F800000 -> iter_cnt_o 0..3, done_o in cycle 8.

Source files
------------

// File: rtl/fp_sqrt_ctrl.sv
// Sequencing control for the single-precision square-root datapath: classifies the operand,
// steps the digit recurrence and strobes the operand, iteration and result registers.
module fp_sqrt_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ITER       = 24,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  busy_o,
    output logic                  op_oe_o,
    output logic                  iter_oe_o,
    output logic                  res_oe_o,
    output logic [1:0]            res_sel_o,
    output logic [CNT_WIDTH-1:0]  iter_cnt_o,
    output logic                  done_o,
    output logic                  invalid_o
);

    localparam logic [CNT_WIDTH-1:0] IterLast = CNT_WIDTH'(ITER - 1);

    localparam logic [1:0] SelComputed = 2'b00;
    localparam logic [1:0] SelZero     = 2'b01;
    localparam logic [1:0] SelInf      = 2'b10;
    localparam logic [1:0] SelNan      = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StClassify,
        StIter,
        StNorm,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           res_sel_q, res_sel_d;
    logic                 invalid_q, invalid_d;
    logic                 special_q, special_d;
    logic                 sign_q, sign_d;
    logic                 exp_max_q, exp_max_d;
    logic                 exp_zero_q, exp_zero_d;
    logic                 frac_nz_q, frac_nz_d;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            res_sel_q  <= SelComputed;
            invalid_q  <= 1'b0;
            special_q  <= 1'b0;
            sign_q     <= 1'b0;
            exp_max_q  <= 1'b0;
            exp_zero_q <= 1'b0;
            frac_nz_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            res_sel_q  <= res_sel_d;
            invalid_q  <= invalid_d;
            special_q  <= special_d;
            sign_q     <= sign_d;
            exp_max_q  <= exp_max_d;
            exp_zero_q <= exp_zero_d;
            frac_nz_q  <= frac_nz_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        res_sel_d  = res_sel_q;
        invalid_d  = invalid_q;
        special_d  = special_q;
        sign_d     = sign_q;
        exp_max_d  = exp_max_q;
        exp_zero_d = exp_zero_q;
        frac_nz_d  = frac_nz_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    sign_d     = data_i[DATA_WIDTH-1];
                    exp_max_d  = &data_i[30:23];
                    exp_zero_d = ~|data_i[30:23];
                    frac_nz_d  = |data_i[22:0];
                    res_sel_d  = SelComputed;
                    invalid_d  = 1'b0;
                    state_d    = StLoad;
                end
            end
            StLoad: state_d = StClassify;
            StClassify: begin
                cnt_d     = '0;
                invalid_d = 1'b0;
                special_d = 1'b1;
                state_d   = StDone;
                // Priority matters: a negative NaN stays a quiet NaN, not an invalid op.
                if (exp_max_q && frac_nz_q) begin
                    res_sel_d = SelNan;
                end else if (sign_q && !(exp_zero_q && !frac_nz_q)) begin
                    res_sel_d = SelNan;
                    invalid_d = 1'b1;
                end else if (exp_max_q) begin
                    res_sel_d = SelInf;
                end else if (exp_zero_q) begin
                    res_sel_d = SelZero;
                end else begin
                    res_sel_d = SelComputed;
                    special_d = 1'b0;
                    state_d   = StIter;
                end
            end
            StIter: begin
                if (cnt_q == IterLast) begin
                    state_d = StNorm;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            StNorm: state_d = StDone;
            StDone: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o     = (state_q != StIdle);
        op_oe_o    = (state_q == StLoad);
        iter_oe_o  = (state_q == StIter);
        res_oe_o   = (state_q == StNorm) || ((state_q == StDone) && special_q);
        done_o     = (state_q == StDone);
        res_sel_o  = res_sel_q;
        invalid_o  = invalid_q;
        iter_cnt_o = cnt_q;
    end

endmodule
